// File: rtl/demux_32b_1_3_reg.sv
// demux_32b_1_3_reg: registered 1-to-3 demultiplexer with a head register,
// a one-entry skid register and a per-port transfer counter.
// Words leave in acceptance order; a stalled head blocks every port.
module demux_32b_1_3_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam int unsigned PORT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [PORT_W-1:0] port;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;

  logic [PORT_W-1:0] in_port_c;
  logic              accept_c;
  logic              head_ready_c;
  logic              drain_c;
  entry_t            in_entry_c;

  // Select 11 is folded onto port 2 at the input so the rest of the block sees 0..2 only.
  assign in_port_c  = (in_sel == 2'b11) ? PORT_W'(2) : in_sel;
  assign in_entry_c = '{valid: 1'b1, port: in_port_c, data: in_data};

  // Ready depends only on registered state, never on the sinks.
  assign in_ready = rst_n && (state_q != TWO);
  assign accept_c = in_valid && in_ready;

  // Sink acceptance for the port the head is addressed to.
  always_comb begin
    head_ready_c = 1'b0;
    case (head_q.port)
      PORT_W'(0): head_ready_c = out0_ready;
      PORT_W'(1): head_ready_c = out1_ready;
      default:    head_ready_c = out2_ready;
    endcase
  end

  assign drain_c = head_q.valid && head_ready_c;

  // Output decode: all ports share the head data, only the addressed one is valid.
  assign out0_data  = head_q.data;
  assign out1_data  = head_q.data;
  assign out2_data  = head_q.data;
  assign out0_valid = rst_n && head_q.valid && (head_q.port == PORT_W'(0));
  assign out1_valid = rst_n && head_q.valid && (head_q.port == PORT_W'(1));
  assign out2_valid = rst_n && head_q.valid && (head_q.port == PORT_W'(2));

  // Next-state and storage update for the head/skid pair.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          head_d  = in_entry_c;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept_c && drain_c) begin
          head_d = in_entry_c;
        end else if (accept_c) begin
          skid_d  = in_entry_c;
          state_d = TWO;
        end else if (drain_c) begin
          head_d.valid = 1'b0;
          state_d      = EMPTY;
        end
      end
      TWO: begin
        if (drain_c) begin
          head_d       = skid_q;
          skid_d.valid = 1'b0;
          state_d      = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and storage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Per-port completed-transfer counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (drain_c) begin
      case (head_q.port)
        PORT_W'(0): cnt0 <= cnt0 + CNT_W'(1);
        PORT_W'(1): cnt1 <= cnt1 + CNT_W'(1);
        default:    cnt2 <= cnt2 + CNT_W'(1);
      endcase
    end
  end

endmodule

// File: tb/tb_demux_32b_1_3_reg.sv
// Testbench for demux_32b_1_3_reg: expected words go into a FIFO scoreboard
// as they are accepted; a negedge monitor pops them as the DUT delivers them.
module tb_demux_32b_1_3_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data;
  logic        out0_valid, out1_valid, out2_valid;
  logic        out0_ready, out1_ready, out2_ready;
  logic [15:0] cnt0, cnt1, cnt2;

  demux_32b_1_3_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid), .out2_valid(out2_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready), .out2_ready(out2_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mcnt[3];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;  // 0: all ready, 1: random, 2: driven by test

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_port(input logic [1:0] s);
    return (s == 2'b11) ? 2 : int'(s);
  endfunction

  // Sink ready generator.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    end else if (rdy_mode == 1) begin
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      out2_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge clk) begin : mon
    logic [2:0]  v, r;
    logic [31:0] d[3];
    logic [15:0] c[3];
    exp_t        e;
    v = {out2_valid, out1_valid, out0_valid};
    r = {out2_ready, out1_ready, out0_ready};
    d[0] = out0_data; d[1] = out1_data; d[2] = out2_data;
    c[0] = cnt0; c[1] = cnt1; c[2] = cnt2;
    if (rst_n === 1'b1) begin
      if (v != 3'b000) chk("onehot_valid", 64'($countones(v)), 64'd1);
      for (int p = 0; p < 3; p++) begin
        if (v[p]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: port %0d data %0h with empty scoreboard", p, d[p]);
          end else begin
            e = exp_q[0];
            chk("route", 64'(p), 64'(e.port));
            chk($sformatf("port%0d_data", p), 64'(d[p]), 64'(e.data));
            if (r[p]) begin
              chk($sformatf("cnt%0d_before_drain", p), 64'(c[p]), 64'(mcnt[p]));
              void'(exp_q.pop_front());
              mcnt[p] = mcnt[p] + 16'd1;
            end
          end
        end
      end
    end
  end

  // Drive one word until accepted; called at posedge+1, returns at posedge+1.
  task automatic send(input logic [31:0] d, input logic [1:0] s);
    int n;
    exp_t e;
    n = 0;
    in_data = d; in_sel = s; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (in_ready) begin
      e.port = eff_port(s);
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) mcnt[i] = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : main
    int t0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 3; i++) mcnt[i] = '0;

    // Reset state while rst_n is held low.
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valids", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    chk("rst_data0", 64'(out0_data), 64'd0);
    chk("rst_cnts", {16'd0, cnt0, cnt1, cnt2}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single word to port 1, one-cycle latency.
    rdy_mode = 0;
    send(32'hDEADBEEF, 2'b01);
    @(negedge clk);
    chk("single_out1_valid", 64'(out1_valid), 64'd1);
    chk("single_out1_data", 64'(out1_data), 64'hDEADBEEF);
    @(negedge clk);
    chk("single_out1_gone", 64'(out1_valid), 64'd0);
    chk("single_cnt1", 64'(cnt1), 64'd1);
    chk("single_cnt0_cnt2", 64'({cnt0, cnt2}), 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream of 8 words at one per cycle.
    do_reset(1);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(32'(i), 2'(i % 3));
    chk("stream_cycles", 64'(cyc - t0), 64'd8);
    wait_drain();
    chk("stream_cnt0", 64'(cnt0), 64'd3);
    chk("stream_cnt1", 64'(cnt1), 64'd3);
    chk("stream_cnt2", 64'(cnt2), 64'd2);

    // Head-of-line stall on port 2.
    do_reset(1);
    rdy_mode = 2;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b0;
    send(32'hAAAA0001, 2'b10);
    send(32'hBBBB0002, 2'b00);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out0_valid", 64'(out0_valid), 64'd0);
    chk("stall_out2_data", 64'({out2_valid, out2_data}), {31'd0, 1'b1, 32'hAAAA0001});
    @(posedge clk); #1 out2_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("stall_b_on_port0", 64'({out0_valid, out0_data}), {31'd0, 1'b1, 32'hBBBB0002});
    @(posedge clk); #1;
    rdy_mode = 0;
    wait_drain();
    chk("stall_cnts", {16'd0, cnt0, cnt1, cnt2}, {16'd0, 16'd1, 16'd0, 16'd1});

    // Select 11 aliases port 2.
    do_reset(1);
    send(32'h12345678, 2'b11);
    @(negedge clk);
    chk("sel11_out2", 64'({out2_valid, out2_data}), {31'd0, 1'b1, 32'h12345678});
    @(posedge clk); #1;
    wait_drain();
    chk("sel11_cnt2", 64'(cnt2), 64'd1);

    // Randomized traffic with random sink back-pressure.
    do_reset(1);
    rdy_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      send($urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    wait_drain();
    chk("rand_cnt0", 64'(cnt0), 64'(mcnt[0]));
    chk("rand_cnt1", 64'(cnt1), 64'(mcnt[1]));
    chk("rand_cnt2", 64'(cnt2), 64'(mcnt[2]));

    // Counter wrap on port 0.
    do_reset(1);
    for (int i = 0; i < 65535; i++) send(32'(i), 2'b00);
    wait_drain();
    chk("wrap_cnt0_max", 64'(cnt0), 64'hFFFF);
    send(32'hCAFEF00D, 2'b00);
    wait_drain();
    chk("wrap_cnt0_zero", 64'(cnt0), 64'd0);

    // Reset while full discards both words.
    do_reset(1);
    rdy_mode = 2;
    out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    send(32'h11111111, 2'b00);
    send(32'h22222222, 2'b01);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) mcnt[i] = '0;
    @(negedge clk);
    chk("midrst_in_ready_low", 64'(in_ready), 64'd0);
    chk("midrst_valids_low", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    chk("postrst_valids", 64'({out2_valid, out1_valid, out0_valid}), 64'd0);
    chk("postrst_cnts", {16'd0, cnt0, cnt1, cnt2}, 64'd0);
    chk("postrst_data", 64'(out1_data), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    send(32'h33333333, 2'b10);
    wait_drain();
    chk("postrst_cnt2", 64'(cnt2), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_32b_1_3_reg.md
DEMUX_32B_1_3_REG -- requirements
Module: demux_32b_1_3_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, as the data word width.
REQ-002 The module SHALL have parameter CNT_W, default 16, as the width of each per-port transfer counter.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 Port in_data  input  WIDTH  SHALL carry the word to route.
REQ-006 Port in_sel  input  2  SHALL carry the destination select: 00 routes to port 0, 01 to port 1, 10 to port 2, and 11 to port 2.
REQ-007 Port in_valid  input  1  SHALL mark in_data and in_sel as valid.
REQ-008 Port in_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-009 Ports out0_data, out1_data, out2_data  output  WIDTH  SHALL each be driven with the head data register.
REQ-010 Ports out0_valid, out1_valid, out2_valid  output  1  SHALL each mark a valid word for that port.
REQ-011 Ports out0_ready, out1_ready, out2_ready  input  1  SHALL each carry sink acceptance for that port.
REQ-012 Ports cnt0, cnt1, cnt2  output  CNT_W  SHALL each count completed transfers on that port.

Function
REQ-013 An accept SHALL occur on an edge where in_valid=1 and in_ready=1; a drain SHALL occur on an edge where the head is valid and outN_ready=1 for N = the head's effective port.
REQ-014 Storage SHALL consist of a head register (data, port, valid) and a one-entry skid register (data, port, valid).
REQ-015 The FSM states SHALL be EMPTY (no entries), ONE (head only) and TWO (head and skid).
REQ-016 In EMPTY, an accept SHALL load the head and move to ONE.
REQ-017 In ONE, accept with drain SHALL load the head from the input and stay in ONE.
REQ-018 In ONE, accept without drain SHALL load the skid and move to TWO.
REQ-019 In ONE, drain without accept SHALL move to EMPTY.
REQ-020 In TWO, a drain SHALL move the skid into the head and move to ONE; no accept is possible in TWO.
REQ-021 in_ready SHALL be 1 exactly when the state is not TWO and rst_n=1, and SHALL be a function of registered state only, with no combinational path from any outN_ready.
REQ-022 outN_valid SHALL be 1 exactly when the head is valid and the head port equals N; at most one outN_valid SHALL be high in any cycle.
REQ-023 The output SHALL hold its data and port stable while outN_valid=1 and outN_ready=0.
REQ-024 Latency: a word accepted at edge k into an empty block SHALL be presented in the cycle following edge k.
REQ-025 Words SHALL leave in acceptance order regardless of destination; a stalled port SHALL block all ports (head-of-line).
REQ-026 Sustained throughput SHALL be one word per cycle when the destination sinks are ready.
REQ-027 cntN SHALL increment by 1 on each drain to port N and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 outN_ready SHALL be ignored while outN_valid=0.
REQ-029 in_sel=11 SHALL behave identically to in_sel=10, including the increment of cnt2.

Reset
REQ-030 On an edge with rst_n=0, the block SHALL set the state to EMPTY, clear both valid bits, clear the head and skid data and ports to 0, and clear cnt0, cnt1 and cnt2 to 0.
REQ-031 While rst_n=0, in_ready and all outN_valid SHALL be 0, and out0_data, out1_data and out2_data SHALL be 0 after the reset edge.
REQ-032 Reset asserted mid-operation, including in TWO, SHALL discard all held words without any drain or counter update.

Verification
REQ-033 Single word, in_sel=01, in_data=0xDEADBEEF, all ready=1 -> out1_valid=1 with data 0xDEADBEEF for one cycle; then cnt1=1 and cnt0=cnt2=0.
REQ-034 Back-to-back stream: 8 words 0..7 cycling sel 00,01,10, all ready=1 -> one word per cycle, in order, on the correct ports; final counts cnt0=3, cnt1=3, cnt2=2.
REQ-035 Stall: out2_ready=0, send A(sel=10) then B(sel=00) -> state TWO, in_ready=0, out0_valid=0; raise out2_ready -> A drains, then B appears on port 0.
REQ-036 in_sel=11 with data 0x12345678 -> out2_valid=1 with data 0x12345678, and cnt2 increments.
REQ-037 Preload cnt0 to 0xFFFF via 65535 transfers, then one more port-0 transfer -> cnt0=0x0000.
REQ-038 Fill to TWO, pulse rst_n=0 for one edge -> all valids=0, counts=0, and in_ready=1 on the cycle after rst_n returns to 1.
